peripheral_gpio_apb_arbiter: RTL
================================

Name: peripheral_gpio_apb_arbiter

Overview:
Round-robin arbiter that shares one APB slave port, such as the GPIO peripheral, between NUM_REQ requesters (e.g. CPU, DMA, debug).
Each requester presents a simple req/gnt/done transfer interface. The block sequences a correct APB SETUP/ACCESS cycle on the shared port and returns read data and error status.
Includes an optional PREADY watchdog so a hung slave cannot lock the bus.

Parameters:
PDATA_SIZE, 8, APB data width; multiple of 8
PADDR_SIZE, 4, APB address width
NUM_REQ, 2, number of requesters; >=2
TIMEOUT, 16, max consecutive ACCESS cycles with PREADY=0 before abort; 0 disables the watchdog

Ports:
PCLK  in  1  clock
PRESETn  in  1  reset; asynchronous, active-low
req_i  in  NUM_REQ  per-requester transfer request (level)
req_addr_i  in  NUM_REQ x PADDR_SIZE  per-requester address
req_write_i  in  NUM_REQ  1=write, 0=read
req_strb_i  in  NUM_REQ x PDATA_SIZE/8  write byte strobes
req_wdata_i  in  NUM_REQ x PDATA_SIZE  write data
gnt_o  out  NUM_REQ  one-hot, one-cycle pulse: request captured
done_o  out  NUM_REQ  one-hot, one-cycle pulse: transfer complete
rdata_o  out  PDATA_SIZE  read data, valid with done_o
slverr_o  out  1  error status, valid with done_o
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PADDR  out  PADDR_SIZE  APB address
PWRITE  out  1  APB direction
PSTRB  out  PDATA_SIZE/8  APB strobes
PWDATA  out  PDATA_SIZE  APB write data
PRDATA  in  PDATA_SIZE  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB error

Behaviour:
- Reset values: all outputs 0. FSM in IDLE. Round-robin last-grant pointer = NUM_REQ-1, so requester 0 has highest priority. Watchdog counter 0.
- Reset asserted mid-transfer: immediate return to reset state. No done_o is issued for the killed transfer.
- FSM states: IDLE, SETUP, ACCESS.
- Arbitration points: only in IDLE, and in ACCESS in the cycle PREADY=1. req_i is ignored in all other cycles.
- Winner selection: the first asserted req_i searching upward (with wrap) from last-grant+1. The pointer updates to the winner.
- On an arbitration win, at the clock edge:
  - capture the winner's addr/write/strb/wdata into the APB output registers;
  - next state SETUP;
  - gnt_o[winner]=1 for exactly the following cycle.
- SETUP: PSEL=1, PENABLE=0. Next state ACCESS unconditionally.
- ACCESS: PSEL=1, PENABLE=1. PADDR/PWRITE/PSTRB/PWDATA are held stable for the whole transfer.
- ACCESS with PREADY=1:
  - register rdata_o=PRDATA (read) or 0 (write), and slverr_o=PSLVERR;
  - done_o[owner]=1 for the next cycle;
  - if any req_i is asserted, arbitrate (back-to-back, next state SETUP, PSEL stays 1); otherwise go to IDLE with PSEL=PENABLE=0.
- Latency: req in IDLE at cycle t -> gnt_o and PSEL at t+1, PENABLE at t+2 -> with zero wait states, done_o at t+3. Back-to-back throughput is 2 cycles per transfer.
- Requester rule: req_i must deassert in the cycle after gnt_o. If it is still high at the next arbitration point, it is a new request.
- rdata_o/slverr_o hold their values until the next completion.
- Watchdog (TIMEOUT>0):
  - counts ACCESS cycles with PREADY=0; clears on entry to SETUP;
  - when the TIMEOUT-th such cycle ends, the transfer is aborted;
  - on abort: PSEL=PENABLE=0, done_o[owner]=1, slverr_o=1, rdata_o=0, next state IDLE;
  - no back-to-back arbitration is made on an abort.
- Simultaneous requests: exactly one gnt per arbitration point; losers stay pending.
- The APB address and control outputs are registers; there is no combinational path from req_i to the APB outputs.

Decomposition:
- Package peripheral_gpio_apb_arbiter_pkg:
  - state enum typedef (IDLE, SETUP, ACCESS);
  - typedef struct for a captured request (addr, write, strb, wdata), parameterised through the package's width constants.
- Sub-module peripheral_gpio_rr_arbiter: combinational round-robin pick from req vector + last-grant pointer, producing a one-hot winner and a valid flag. The pointer register lives in the top.

Test Plan:
- Write, no wait states: req0 addr=1 write strb=1 wdata=0xFF at t -> gnt_o=01 at t+1, PSEL=1/PENABLE=0/PADDR=1/PWDATA=0xFF at t+1, PENABLE=1 at t+2, done_o=01 slverr_o=0 at t+3.
- Read: req1 read addr=3, slave PRDATA=0xA5 -> done_o=10, rdata_o=0xA5, PWRITE=0 throughout.
- Fairness: req0 held high continuously, req1 asserted from reset -> grants alternate 0,1,0,1. PSEL never drops between transfers. Transfers complete every 2 cycles.
- Wait states: PREADY=0 for 3 ACCESS cycles -> PENABLE held high, PADDR/PWDATA stable, single done_o in the cycle after PREADY=1; PSLVERR=1 then -> slverr_o=1.
- Timeout: TIMEOUT=4, PREADY stuck 0 -> abort after 4 ACCESS cycles: PSEL=0, done_o owner pulse, slverr_o=1, rdata_o=0, FSM in IDLE. A following request completes normally.
- Reset mid-ACCESS: PRESETn low -> all outputs 0 immediately, no done_o. After release, simultaneous req0/req1 -> req0 granted first.

Source files
------------

// File: rtl/peripheral_gpio_apb_arbiter_pkg.sv
// Shared types and default widths for the GPIO APB arbiter slice.
package peripheral_gpio_apb_arbiter_pkg;

  localparam int ARB_PDATA_SIZE = 8;
  localparam int ARB_PADDR_SIZE = 4;
  localparam int ARB_NUM_REQ    = 2;
  localparam int ARB_TIMEOUT    = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  // Request fields latched at the arbitration win; they drive the APB outputs.
  typedef struct packed {
    logic [ARB_PADDR_SIZE-1:0]   addr;
    logic                        write;
    logic [ARB_PDATA_SIZE/8-1:0] strb;
    logic [ARB_PDATA_SIZE-1:0]   wdata;
  } apb_req_t;

endpackage

// File: rtl/peripheral_gpio_rr_arbiter.sv
// Combinational round-robin pick: first asserted request above the last grant, with wrap.
module peripheral_gpio_rr_arbiter
  import peripheral_gpio_apb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = ARB_NUM_REQ,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [NUM_REQ-1:0] onehot_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  logic [IDX_W-1:0] cand_s;
  logic             hit_s;

  // Walk the requesters starting one past the last grant; the first hit wins.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    cand_s   = '0;
    hit_s    = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand_s           = IDX_W'((int'(last_i) + off) % NUM_REQ);
      hit_s            = req_i[cand_s] & ~valid_o;
      onehot_o[cand_s] = onehot_o[cand_s] | hit_s;
      idx_o            = hit_s ? cand_s : idx_o;
      valid_o          = valid_o | hit_s;
    end
  end

endmodule

// File: rtl/peripheral_gpio_apb_arbiter.sv
// Round-robin sharing of one APB slave port between NUM_REQ requesters,
// with an optional PREADY watchdog that aborts a hung transfer.
module peripheral_gpio_apb_arbiter
  import peripheral_gpio_apb_arbiter_pkg::*;
#(
  parameter int PDATA_SIZE = ARB_PDATA_SIZE,
  parameter int PADDR_SIZE = ARB_PADDR_SIZE,
  parameter int NUM_REQ    = ARB_NUM_REQ,
  parameter int TIMEOUT    = ARB_TIMEOUT
) (
  input  logic                                  PCLK,
  input  logic                                  PRESETn,
  input  logic [NUM_REQ-1:0]                    req_i,
  input  logic [NUM_REQ-1:0][PADDR_SIZE-1:0]    req_addr_i,
  input  logic [NUM_REQ-1:0]                    req_write_i,
  input  logic [NUM_REQ-1:0][PDATA_SIZE/8-1:0]  req_strb_i,
  input  logic [NUM_REQ-1:0][PDATA_SIZE-1:0]    req_wdata_i,
  output logic [NUM_REQ-1:0]                    gnt_o,
  output logic [NUM_REQ-1:0]                    done_o,
  output logic [PDATA_SIZE-1:0]                 rdata_o,
  output logic                                  slverr_o,
  output logic                                  PSEL,
  output logic                                  PENABLE,
  output logic [PADDR_SIZE-1:0]                 PADDR,
  output logic                                  PWRITE,
  output logic [PDATA_SIZE/8-1:0]               PSTRB,
  output logic [PDATA_SIZE-1:0]                 PWDATA,
  input  logic [PDATA_SIZE-1:0]                 PRDATA,
  input  logic                                  PREADY,
  input  logic                                  PSLVERR
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(NUM_REQ - 1);

  function automatic logic [NUM_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  apb_state_e                state_q, state_d;
  logic [IDX_W-1:0]          ptr_q, ptr_d;
  logic [IDX_W-1:0]          owner_q, owner_d;
  apb_req_t                  cap_q, cap_d;
  logic                      psel_q, psel_d;
  logic                      penable_q, penable_d;
  logic [NUM_REQ-1:0]        gnt_q, gnt_d;
  logic [NUM_REQ-1:0]        done_q, done_d;
  logic [PDATA_SIZE-1:0]     rdata_q, rdata_d;
  logic                      slverr_q, slverr_d;
  logic [WD_W-1:0]           wdog_q, wdog_d;

  logic [NUM_REQ-1:0]        win_onehot_s;
  logic [IDX_W-1:0]          win_idx_s;
  logic                      win_valid_s;
  logic                      arb_win_s;

  peripheral_gpio_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req_i    (req_i),
    .last_i   (ptr_q),
    .onehot_o (win_onehot_s),
    .idx_o    (win_idx_s),
    .valid_o  (win_valid_s)
  );

  // Next-state, APB phase, completion and watchdog logic.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    cap_d     = cap_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    gnt_d     = '0;
    done_d    = '0;
    rdata_d   = rdata_q;
    slverr_d  = slverr_q;
    wdog_d    = wdog_q;
    arb_win_s = 1'b0;

    case (state_q)
      IDLE: begin
        if (win_valid_s) begin
          arb_win_s = 1'b1;
        end else begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        psel_d    = 1'b1;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (PREADY) begin
          rdata_d  = cap_q.write ? '0 : PRDATA;
          slverr_d = PSLVERR;
          done_d   = idx_onehot(owner_q);
          if (win_valid_s) begin
            arb_win_s = 1'b1;
          end else begin
            state_d   = IDLE;
            psel_d    = 1'b0;
            penable_d = 1'b0;
          end
        end else if ((TIMEOUT > 0) && (wdog_q == WD_LAST)) begin
          // Hung slave: release the bus and report an error to the owner.
          state_d   = IDLE;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          done_d    = idx_onehot(owner_q);
          slverr_d  = 1'b1;
          rdata_d   = '0;
          wdog_d    = '0;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase

    if (arb_win_s) begin
      state_d     = SETUP;
      psel_d      = 1'b1;
      penable_d   = 1'b0;
      gnt_d       = win_onehot_s;
      ptr_d       = win_idx_s;
      owner_d     = win_idx_s;
      wdog_d      = '0;
      cap_d.addr  = req_addr_i[win_idx_s];
      cap_d.write = req_write_i[win_idx_s];
      cap_d.strb  = req_strb_i[win_idx_s];
      cap_d.wdata = req_wdata_i[win_idx_s];
    end else begin
      cap_d = cap_q;
    end
  end

  // State and output registers; reset returns everything to idle with requester 0 first.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      ptr_q     <= PTR_RST;
      owner_q   <= '0;
      cap_q     <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      gnt_q     <= '0;
      done_q    <= '0;
      rdata_q   <= '0;
      slverr_q  <= 1'b0;
      wdog_q    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      cap_q     <= cap_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      slverr_q  <= slverr_d;
      wdog_q    <= wdog_d;
    end
  end

  assign gnt_o    = gnt_q;
  assign done_o   = done_q;
  assign rdata_o  = rdata_q;
  assign slverr_o = slverr_q;
  assign PSEL     = psel_q;
  assign PENABLE  = penable_q;
  assign PADDR    = cap_q.addr;
  assign PWRITE   = cap_q.write;
  assign PSTRB    = cap_q.strb;
  assign PWDATA   = cap_q.wdata;

endmodule
